// File: rtl/exec_issue_arbiter.sv
// Round-robin issue arbiter sharing one execute unit between two issue ports,
// with an occupancy counter that tracks in-flight long-latency instructions.
module exec_issue_arbiter #(
    parameter int unsigned LONG_LAT = 4,
    parameter int unsigned CW       = $clog2(LONG_LAT + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    req_valid,
    input  logic [1:0]    req_is_long,
    input  logic          exec_stall,
    output logic [1:0]    grant,
    output logic          issue_valid,
    output logic          issue_src,
    output logic          issue_is_long,
    output logic          exec_busy,
    output logic          exec_will_free_next,
    output logic          rr_ptr,
    output logic [CW-1:0] busy_cnt
);

    localparam logic [CW-1:0] RELOAD = CW'(LONG_LAT - 1);

    logic can_accept;

    assign exec_busy           = (busy_cnt != '0);
    assign exec_will_free_next = (busy_cnt == CW'(1)) && !exec_stall;
    // The last occupancy cycle overlaps the next accept.
    assign can_accept          = !reset && !exec_stall && (busy_cnt <= CW'(1));

    always_comb begin
        grant = 2'b00;
        if (can_accept) begin
            unique case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = rr_ptr ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    assign issue_valid   = |grant;
    assign issue_src     = grant[1];
    assign issue_is_long = |(grant & req_is_long);

    // A long grant reloads the counter ahead of stall-freeze and decrement.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_cnt <= '0;
            rr_ptr   <= 1'b0;
        end else begin
            if (issue_valid) begin
                rr_ptr <= ~issue_src;
            end
            if (issue_valid && issue_is_long) begin
                busy_cnt <= RELOAD;
            end else if (exec_stall) begin
                busy_cnt <= busy_cnt;
            end else if (busy_cnt != '0) begin
                busy_cnt <= busy_cnt - CW'(1);
            end
        end
    end

endmodule

// File: doc/exec_issue_arbiter.md
Name: exec_issue_arbiter

Overview:
- Shares one execute unit between two instruction-buffer issue ports (thread/lane 0 and 1).
- Grants one instruction per cycle using round-robin between the two ports.
- Tracks how long the execute unit is occupied by long-latency instructions.
- Generates the exec_busy / exec_will_free_next pair that the instruction buffers consume.

Parameters:
- LONG_LAT, 4: cycles a long instruction occupies execute. Legal range >= 2.
- CW, $clog2(LONG_LAT+1): width of the occupancy counter (derived; do not override).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  2  bit i: port i presents an instruction this cycle.
- req_is_long  input  2  bit i: port i's instruction is long-latency. Ignored when req_valid[i]=0.
- exec_stall  input  1  external execute freeze (e.g. memory wait).
- grant  output  2  one-hot or zero. Port i's instruction is accepted this cycle (combinational).
- issue_valid  output  1  an instruction enters execute this cycle. Equals |grant.
- issue_src  output  1  index of the granted port. 0 when issue_valid=0.
- issue_is_long  output  1  req_is_long of the granted port. 0 when issue_valid=0.
- exec_busy  output  1  execute occupied by an in-flight long instruction.
- exec_will_free_next  output  1  in-flight long instruction completes this cycle.
- rr_ptr  output  1  debug: port favoured on the next contention.
- busy_cnt  output  CW  debug: remaining occupancy cycles.

Behaviour:
- All ports are synchronous to clk; reset is sampled only on the rising edge.
- State:
  - busy_cnt, CW bits.
  - rr_ptr, 1 bit.
  - Reset values: busy_cnt=0, rr_ptr=0.
- Derived outputs:
  - exec_busy = (busy_cnt != 0).
  - exec_will_free_next = (busy_cnt == 1) && !exec_stall.
  - can_accept = !reset && !exec_stall && (busy_cnt <= 1).
- Grant rules:
  - Only one port valid and can_accept: that port is granted.
  - Both ports valid and can_accept: port rr_ptr is granted.
  - can_accept=0: grant=2'b00.
- Round-robin pointer:
  - On any grant to port g, rr_ptr <= ~g next edge.
  - With no grant, rr_ptr holds.
  - A single requester is granted repeatedly.
- Occupancy counter, priority in this order:
  1. reset: busy_cnt <= 0.
  2. Grant of a long instruction: busy_cnt <= LONG_LAT-1.
  3. exec_stall=1: busy_cnt holds.
  4. busy_cnt != 0: busy_cnt <= busy_cnt-1.
  5. Otherwise busy_cnt holds at 0.
- Short instructions never load busy_cnt. Back-to-back short issues are allowed every cycle.
- Long instruction issued at cycle t:
  - exec_busy is high for cycles t+1 .. t+LONG_LAT-1.
  - The next grant is possible at cycle t+LONG_LAT-1, the cycle where busy_cnt==1 (its completion overlaps the accept).
  - Example, LONG_LAT=4: issues at t0 and t3 at the earliest.
- Simultaneous completion and long grant in the same cycle: the reload to LONG_LAT-1 wins over the decrement.
- exec_stall:
  - Blocks all grants and freezes busy_cnt.
  - Suppresses exec_will_free_next.
  - rr_ptr holds.
  - Releasing the stall resumes from the frozen state with no lost cycles.
- Reset:
  - Takes effect at the next edge; grant is forced to 0 during any cycle with reset=1.
  - Reset during a long occupancy: busy_cnt=0 and exec_busy=0 on the following cycle. The in-flight op is abandoned.
  - Reset values of all outputs: grant=0, issue_valid=0, issue_src=0, issue_is_long=0, exec_busy=0, exec_will_free_next=0, rr_ptr=0, busy_cnt=0.
- Interface contract:
  - A requester holds req_valid and req_is_long stable until granted.
  - The arbiter does not check this contract.
- Latency: grant is zero-cycle, combinational from req_valid and state. State updates one edge later.

Test Plan:
- Reset then req_valid=2'b11, both short, for 4 cycles -> grant 01, 10, 01, 10; rr_ptr alternates; exec_busy stays 0.
- req_valid=2'b01, long, at t0, then port 1 short requesting from t1:
  - grant[0]=1 at t0; busy_cnt=3,2,1 at t1..t3.
  - exec_busy=1 at t1..t3; exec_will_free_next=1 at t3 only.
  - grant[1]=1 at t3; no grant at t1 or t2.
- Long grant at t0, exec_stall=1 at t2..t4 -> busy_cnt frozen at 2 through t4; no grants; next grant at t6.
- Long instructions from both ports continuously -> grants at t0 (port 0), t3 (port 1), t6 (port 0); busy_cnt reloads to 3 at each grant.
- reset asserted at t2 of a long occupancy while req_valid=2'b11:
  - grant=0 at t2; busy_cnt=0 and rr_ptr=0 at t3.
  - port 0 is granted at t3 once reset deasserts.
- Long grant coincident with busy_cnt==1 -> busy_cnt becomes 3, not 0; exec_busy stays continuously 1.
